// File: rtl/temp_control_multi.sv
// Multi-zone hysteresis thermostat: one IDLE/COOLDOWN/HEATUP FSM per zone sharing
// one threshold pair, with a minimum dwell time, a sample qualifier and a config sanity check.
module temp_control_multi #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int HYST      = 5,
  parameter int MIN_DWELL = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [WIDTH-1:0]          cooldown_th,
  input  logic [WIDTH-1:0]          heatup_th,
  input  logic [CHANNELS*WIDTH-1:0] temps,
  input  logic                      sample_valid,
  output logic [CHANNELS-1:0]       cool_out,
  output logic [CHANNELS-1:0]       heat_out,
  output logic [2*CHANNELS-1:0]     state_out,
  output logic                      cfg_err
);

  // state    | meaning
  // S_IDLE   | no actuator driven
  // S_COOL   | fan on until t <= hot_exit and dwell expired
  // S_HEAT   | heater on until t >= cold_exit and dwell expired
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COOL = 2'd1,
    S_HEAT = 2'd2
  } state_t;

  localparam int EW = WIDTH + 2;
  localparam int DW = (MIN_DWELL > 0) ? $clog2(MIN_DWELL + 1) : 1;
  localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL);
  localparam logic signed [EW-1:0] HYST_E = EW'(HYST);

  // Two guard bits so threshold +/- HYST can never wrap
  logic signed [EW-1:0] cool_th_e, heat_th_e, hot_exit, cold_exit;
  logic signed [EW-1:0] t_e [CHANNELS];
  logic                 cfg_err_d, force_idle;

  state_t               state_q [CHANNELS];
  logic [DW-1:0]        dwell_q [CHANNELS];
  logic                 cfg_err_q;

  assign cool_th_e  = {{2{cooldown_th[WIDTH-1]}}, cooldown_th};
  assign heat_th_e  = {{2{heatup_th[WIDTH-1]}}, heatup_th};
  assign hot_exit   = cool_th_e - HYST_E;
  assign cold_exit  = heat_th_e + HYST_E;
  assign cfg_err_d  = (cold_exit >= hot_exit);
  assign force_idle = !enable || cfg_err_d;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      t_e[i] = {{2{temps[i*WIDTH+WIDTH-1]}}, temps[i*WIDTH +: WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_err_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_IDLE;
        dwell_q[i] <= '0;
      end
    end else begin
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < CHANNELS; i++) begin
        if (force_idle) begin
          state_q[i] <= S_IDLE;
          dwell_q[i] <= '0;
        end else begin
          // Entry loads below override this free-running countdown
          dwell_q[i] <= (dwell_q[i] != '0) ? dwell_q[i] - DW'(1) : '0;
          if (sample_valid) begin
            case (state_q[i])
              S_IDLE: begin
                if (t_e[i] >= cool_th_e) begin
                  state_q[i] <= S_COOL;
                  dwell_q[i] <= DWELL_LOAD;
                end else if (t_e[i] <= heat_th_e) begin
                  state_q[i] <= S_HEAT;
                  dwell_q[i] <= DWELL_LOAD;
                end
              end
              S_COOL: begin
                if (dwell_q[i] == '0 && t_e[i] <= hot_exit) state_q[i] <= S_IDLE;
              end
              S_HEAT: begin
                if (dwell_q[i] == '0 && t_e[i] >= cold_exit) state_q[i] <= S_IDLE;
              end
              default: state_q[i] <= S_IDLE;
            endcase
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cool_out[i]         = (state_q[i] == S_COOL);
      heat_out[i]         = (state_q[i] == S_HEAT);
      state_out[2*i +: 2] = state_q[i];
    end
  end

  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_temp_control_multi.sv
// Bench for temp_control_multi: vector table, directed dwell/signed/reset sequences,
// and random traffic against an integer-arithmetic zone model.
module tb_temp_control_multi;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int H  = 5;
  localparam int MD = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic           sample_valid;
  logic [W-1:0]   cooldown_th, heatup_th;
  logic [N*W-1:0] temps;
  logic [N-1:0]   cool_out, heat_out;
  logic [2*N-1:0] state_out;
  logic           cfg_err;

  temp_control_multi #(.WIDTH(W), .CHANNELS(N), .HYST(H), .MIN_DWELL(MD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cooldown_th(cooldown_th),
    .heatup_th(heatup_th), .temps(temps), .sample_valid(sample_valid),
    .cool_out(cool_out), .heat_out(heat_out), .state_out(state_out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Zone model: 0 idle, 1 cooling, 2 heating; dwell counts remaining hold edges
  int m_state[N];
  int m_dwell[N];
  bit m_cfg;

  bit d_en, d_sv;
  int d_cth, d_hth;
  int d_t[N];

  typedef struct {
    bit en; bit sv; int cth; int hth;
    int t0; int t1; int t2; int t3;
    int s0; int s1; int s2; int s3;
    bit cfg;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0;
      m_dwell[i] = 0;
    end
    m_cfg = 1'b0;
  endtask

  task automatic model_step();
    int hot, cold, nd;
    hot   = d_cth - H;
    cold  = d_hth + H;
    m_cfg = (cold >= hot);
    for (int i = 0; i < N; i++) begin
      if (!d_en || m_cfg) begin
        m_state[i] = 0;
        m_dwell[i] = 0;
      end else begin
        nd = (m_dwell[i] > 0) ? m_dwell[i] - 1 : 0;
        if (d_sv) begin
          if (m_state[i] == 0) begin
            if (d_t[i] >= d_cth) begin m_state[i] = 1; nd = MD; end
            else if (d_t[i] <= d_hth) begin m_state[i] = 2; nd = MD; end
          end else if (m_state[i] == 1) begin
            if (m_dwell[i] == 0 && d_t[i] <= hot) m_state[i] = 0;
          end else begin
            if (m_dwell[i] == 0 && d_t[i] >= cold) m_state[i] = 0;
          end
        end
        m_dwell[i] = nd;
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [31:0] es, ec, eh;
    es = '0; ec = '0; eh = '0;
    for (int i = 0; i < N; i++) begin
      es[2*i +: 2] = 2'(m_state[i]);
      ec[i] = (m_state[i] == 1);
      eh[i] = (m_state[i] == 2);
    end
    chk({name, " state_out"}, 32'(state_out), es);
    chk({name, " cool_out"}, 32'(cool_out), ec);
    chk({name, " heat_out"}, 32'(heat_out), eh);
    chk({name, " cfg_err"}, 32'(cfg_err), 32'(m_cfg));
  endtask

  task automatic drive();
    enable       = d_en;
    sample_valid = d_sv;
    cooldown_th  = d_cth[W-1:0];
    heatup_th    = d_hth[W-1:0];
    for (int i = 0; i < N; i++) temps[i*W +: W] = d_t[i][W-1:0];
  endtask

  task automatic tick(input string name);
    drive();
    model_step();
    @(posedge clk);
    #1;
    check_model(name);
  endtask

  task automatic set_t(input int a, input int b, input int c, input int d);
    d_t[0] = a; d_t[1] = b; d_t[2] = c; d_t[3] = d;
  endtask

  task automatic chk_ch(input string name, input int ch, input int exp);
    chk(name, 32'(state_out[2*ch +: 2]), 32'(exp));
  endtask

  initial begin
    int es[N];

    vecs[0] = '{1, 1, 95, 60, 100, 55, 70, -20, 1, 2, 0, 2, 0};
    vecs[1] = '{1, 0, 95, 60, -128, 127, -128, 127, 1, 2, 0, 2, 0};
    vecs[2] = '{1, 1, 95, 60, 89, 70, 127, 70, 1, 2, 1, 2, 0};
    vecs[3] = '{1, 1, 70, 62, 70, 70, 70, 70, 0, 0, 0, 0, 1};
    vecs[4] = '{1, 1, 95, 60, 70, 70, 70, 70, 0, 0, 0, 0, 0};
    vecs[5] = '{0, 1, 95, 60, 100, 100, 0, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{1, 1, 95, 60, 95, 60, 94, 61, 1, 2, 0, 0, 0};

    rst = 1'b0;
    d_en = 1'b1; d_sv = 1'b1; d_cth = 95; d_hth = 60;
    set_t(100, 55, 70, -20);
    drive();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset state_out", 32'(state_out), 32'h0);
    chk("reset cool_out", 32'(cool_out), 32'h0);
    chk("reset heat_out", 32'(heat_out), 32'h0);
    chk("reset cfg_err", 32'(cfg_err), 32'h0);
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      d_en = vecs[k].en; d_sv = vecs[k].sv;
      d_cth = vecs[k].cth; d_hth = vecs[k].hth;
      set_t(vecs[k].t0, vecs[k].t1, vecs[k].t2, vecs[k].t3);
      tick($sformatf("vec%0d model", k));
      es = '{vecs[k].s0, vecs[k].s1, vecs[k].s2, vecs[k].s3};
      for (int i = 0; i < N; i++) chk_ch($sformatf("vec%0d ch%0d", k, i), i, es[i]);
      chk($sformatf("vec%0d cfg_err", k), 32'(cfg_err), 32'(vecs[k].cfg));
    end

    // Earliest exit: dwell must fully expire before hot_exit releases COOLDOWN
    d_en = 1'b0; tick("idle flush");
    d_en = 1'b1; d_sv = 1'b1; d_cth = 95; d_hth = 60;
    set_t(100, 70, 70, 70); tick("dwell entry");
    chk_ch("dwell entry ch0", 0, 1);
    d_t[0] = 90;
    for (int j = 1; j <= 16; j++) begin
      tick("dwell hold");
      chk_ch($sformatf("dwell hold %0d", j), 0, 1);
    end
    tick("dwell exit");
    chk_ch("dwell exit ch0", 0, 0);

    // Hysteresis band: 91 holds, 90 releases
    d_t[0] = 100; tick("hyst entry");
    d_t[0] = 89;
    for (int j = 0; j < 4; j++) tick("hyst 89");
    chk_ch("hyst 89 ch0", 0, 1);
    d_t[0] = 91;
    for (int j = 0; j < 13; j++) tick("hyst 91");
    chk_ch("hyst 91 ch0", 0, 1);
    d_t[0] = 90; tick("hyst 90");
    chk("hyst 90 cool0", 32'(cool_out[0]), 32'h0);

    // Signed extremes
    d_cth = 20; d_hth = -10; set_t(-128, 0, 0, 0); tick("signed entry");
    chk_ch("signed heat ch0", 0, 2);
    for (int j = 0; j < 15; j++) tick("signed hold");
    tick("signed hold last");
    chk_ch("signed hold ch0", 0, 2);
    d_t[0] = 127; tick("signed exit");
    chk_ch("signed exit ch0", 0, 0);
    d_cth = -128; d_hth = -128; tick("wide cfg low");
    chk("wide cfg low", 32'(cfg_err), 32'h1);
    d_cth = 127; d_hth = -128; set_t(127, -128, 0, 0); tick("wide ok");
    chk("wide ok cfg", 32'(cfg_err), 32'h0);
    chk("wide ok state", 32'(state_out), 32'h09);
    d_cth = 127; d_hth = 127; tick("wide cfg high");
    chk("wide cfg high", 32'(cfg_err), 32'h1);
    chk("wide cfg high state", 32'(state_out), 32'h0);

    // Enable drop mid-dwell
    d_cth = 95; d_hth = 60; set_t(100, 70, 70, 70); tick("en entry");
    for (int j = 0; j < 6; j++) tick("en dwell");
    d_en = 1'b0; tick("en drop");
    chk_ch("en drop ch0", 0, 0);
    d_en = 1'b1; d_sv = 1'b0; set_t(127, -128, 127, -128); tick("sv low");
    chk("sv low state", 32'(state_out), 32'h0);

    // Async reset between edges
    d_sv = 1'b1; set_t(100, 100, 100, 100); tick("all cool");
    chk("all cool", 32'(cool_out), 32'hF);
    #2 rst = 1'b0;
    #1;
    chk("async rst cool_out", 32'(cool_out), 32'h0);
    chk("async rst state_out", 32'(state_out), 32'h0);
    model_reset();
    #1 rst = 1'b1;
    set_t(70, 70, 70, 70); tick("post rst");

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      d_en = ($urandom_range(0, 15) != 0);
      d_sv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        d_cth = int'($urandom_range(0, 255)) - 128;
        d_hth = int'($urandom_range(0, 255)) - 128;
      end else if ($urandom_range(0, 9) == 0) begin
        d_cth = 95; d_hth = 60;
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 4) == 0) d_t[i] = int'($urandom_range(0, 255)) - 128;
        else d_t[i] = int'($urandom_range(50, 105));
      end
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
